// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one LPDDR2 port between instruction fetch and data.
// Define MEM_ARBITER_TIMEOUT_EN to abort accesses that sit in WAIT for TIMEOUT_CYCLES cycles.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [29:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        d_rreq,
    input  logic        d_wreq,
    input  logic [29:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic [26:0] lpddr2_address,
    output logic [31:0] lpddr2_write_data,
    input  logic [31:0] lpddr2_read_data,
    output logic        lpddr2_rreq,
    output logic        lpddr2_wreq,
    input  logic        lpddr2_ack,
    output logic        busy,
    output logic        grant,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_grant;
    logic        r_we;
    logic        r_err;
    logic        r_last_data;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    logic        w_any_d;
    logic        w_start;
    logic        w_grant_next;
    logic        w_oor;
    logic        w_active;
    logic        w_timeout;
    logic        w_done_entry;
    logic        w_fault;
    logic [31:0] w_done_data;

    assign w_any_d      = d_rreq | d_wreq;
    assign w_start      = (r_state == IDLE) && (if_req || w_any_d);
    // On contention the side that was not served last wins.
    assign w_grant_next = (if_req && w_any_d) ? ~r_last_data : w_any_d;
    assign w_oor        = |r_addr[29:27];
    assign w_active     = ((r_state == ISSUE) || (r_state == WAIT)) && !w_oor;
    assign w_done_data  = w_fault ? 32'd0 : lpddr2_read_data;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (w_start) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == WAIT) && (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // The parameter has no effect when the timeout feature is left out.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_done_entry = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) w_state_next = ISSUE;
            end
            ISSUE: begin
                if (w_oor) begin
                    w_state_next = DONE;
                    w_done_entry = 1'b1;
                    w_fault      = 1'b1;
                end else if (lpddr2_ack) begin
                    w_state_next = DONE;
                    w_done_entry = 1'b1;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (lpddr2_ack) begin
                    w_state_next = DONE;
                    w_done_entry = 1'b1;
                end else if (w_timeout) begin
                    w_state_next = DONE;
                    w_done_entry = 1'b1;
                    w_fault      = 1'b1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_last_data <= 1'b1;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_grant <= w_grant_next;
                r_addr  <= w_grant_next ? d_addr : if_addr;
                r_we    <= w_grant_next & d_wreq;
                r_err   <= w_grant_next & d_rreq & d_wreq;
                r_wdata <= w_grant_next ? d_wdata : 32'd0;
            end
            if (w_done_entry) begin
                r_last_data <= r_grant;
                if (w_fault) r_err <= 1'b1;
                if (r_grant) r_d_rdata  <= w_done_data;
                else         r_if_rdata <= w_done_data;
            end
        end
    end

    assign busy              = (r_state != IDLE);
    assign grant             = r_grant;
    assign if_ack            = (r_state == DONE) && !r_grant;
    assign d_ack             = (r_state == DONE) && r_grant;
    assign err               = (r_state == DONE) && r_err;
    assign if_rdata          = r_if_rdata;
    assign d_rdata           = r_d_rdata;
    assign lpddr2_rreq       = w_active && !r_we;
    assign lpddr2_wreq       = w_active && r_we;
    assign lpddr2_address    = r_addr[26:0];
    assign lpddr2_write_data = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-age model checked every cycle plus literal expectations.
module tb_mem_arbiter;

    localparam int TO = 4;
`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [29:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_rreq = 1'b0;
    logic        d_wreq = 1'b0;
    logic [29:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic [26:0] lpddr2_address;
    logic [31:0] lpddr2_write_data;
    logic [31:0] lpddr2_read_data = '0;
    logic        lpddr2_rreq;
    logic        lpddr2_wreq;
    logic        lpddr2_ack = 1'b0;
    logic        busy;
    logic        grant;
    logic        err;

    mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_rreq(d_rreq), .d_wreq(d_wreq), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .lpddr2_address(lpddr2_address), .lpddr2_write_data(lpddr2_write_data),
        .lpddr2_read_data(lpddr2_read_data), .lpddr2_rreq(lpddr2_rreq),
        .lpddr2_wreq(lpddr2_wreq), .lpddr2_ack(lpddr2_ack),
        .busy(busy), .grant(grant), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder: acks mem_delay cycles after the request first appears, or on a kick.
    int          mem_delay = -1;
    logic [31:0] mem_data = '0;
    int          mem_cnt = 0;
    int          kick_req = 0;
    int          kick_done = 0;

    always @(posedge clk) begin
        #1;
        lpddr2_ack = 1'b0;
        if (kick_req != kick_done) begin
            lpddr2_ack       = 1'b1;
            lpddr2_read_data = mem_data;
            kick_done++;
        end else if (lpddr2_rreq || lpddr2_wreq) begin
            if (mem_cnt == mem_delay) begin
                lpddr2_ack       = 1'b1;
                lpddr2_read_data = mem_data;
            end
            mem_cnt++;
        end else begin
            mem_cnt = 0;
        end
    end

    // Model: age 0 = idle, age n = n-th cycle after the sampling edge; ack cycle at m_ack_age.
    int          m_age = 0;
    int          m_ack_age = 0;
    logic        m_owner = 1'b0;
    logic        m_last_owner = 1'b1;
    logic        m_we = 1'b0;
    logic        m_err = 1'b0;
    logic [29:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata = '0;
    logic        e_ack;
    logic        e_req;
    logic        m_any_d;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_busy", busy, 0);
            check("rst_grant", grant, 0);
            check("rst_if_ack", if_ack, 0);
            check("rst_d_ack", d_ack, 0);
            check("rst_err", err, 0);
            check("rst_rreq", lpddr2_rreq, 0);
            check("rst_wreq", lpddr2_wreq, 0);
            check("rst_address", lpddr2_address, 0);
            check("rst_wdata", lpddr2_write_data, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            m_age = 0; m_ack_age = 0; m_owner = 1'b0; m_last_owner = 1'b1;
            m_we = 1'b0; m_err = 1'b0; m_addr = '0; m_wdata = '0; m_pend = '0;
            m_if_rdata = '0; m_d_rdata = '0;
        end else begin
            e_ack = (m_age > 0) && (m_age == m_ack_age);
            e_req = (m_age > 0) && !e_ack && (m_addr[29:27] == 3'd0);
            check("busy", busy, (m_age > 0));
            check("grant", grant, m_owner);
            check("if_ack", if_ack, e_ack && !m_owner);
            check("d_ack", d_ack, e_ack && m_owner);
            check("err", err, e_ack && m_err);
            check("rreq", lpddr2_rreq, e_req && !m_we);
            check("wreq", lpddr2_wreq, e_req && m_we);
            check("if_rdata", if_rdata, m_if_rdata);
            check("d_rdata", d_rdata, m_d_rdata);
            if (e_req) check("address", lpddr2_address, {5'd0, m_addr[26:0]});
            if (e_req && m_we) check("write_data", lpddr2_write_data, m_wdata);

            if (m_age == 0) begin
                m_any_d = d_rreq || d_wreq;
                if (if_req || m_any_d) begin
                    m_owner   = m_any_d && (!if_req || !m_last_owner);
                    m_addr    = m_owner ? d_addr : if_addr;
                    m_we      = m_owner && d_wreq;
                    m_wdata   = d_wdata;
                    m_err     = m_owner && d_rreq && d_wreq;
                    m_age     = 1;
                    m_ack_age = 0;
                    if (m_addr[29:27] != 3'd0) begin
                        m_ack_age = 2;
                        m_pend    = 32'd0;
                        m_err     = 1'b1;
                    end
                end
            end else if (e_ack) begin
                m_age = 0;
            end else begin
                if (m_ack_age == 0) begin
                    if (lpddr2_ack) begin
                        m_ack_age = m_age + 1;
                        m_pend    = lpddr2_read_data;
                    end else if (TO_EN && (m_age == TO + 1)) begin
                        m_ack_age = m_age + 1;
                        m_pend    = 32'd0;
                        m_err     = 1'b1;
                    end
                end
                if (m_ack_age == m_age + 1) begin
                    if (m_owner) m_d_rdata = m_pend;
                    else         m_if_rdata = m_pend;
                    m_last_owner = m_owner;
                end
                m_age = m_age + 1;
            end
        end
    end

    // Stimulus-side observation of one access, up to and including its ack cycle.
    int          lat;
    logic [26:0] s_addr;
    logic [31:0] s_wdata;
    logic        s_rreq, s_wreq, a_if, a_d, a_err, a_grant;

    task automatic run_until_ack();
        lat = 0; s_addr = '0; s_wdata = '0; s_rreq = 0; s_wreq = 0;
        a_if = 0; a_d = 0; a_err = 0; a_grant = 0;
        while (lat < 40) begin
            step();
            lat++;
            if (lpddr2_rreq || lpddr2_wreq) begin
                s_addr  = lpddr2_address;
                s_wdata = lpddr2_write_data;
                s_rreq  = s_rreq | lpddr2_rreq;
                s_wreq  = s_wreq | lpddr2_wreq;
            end
            if (if_ack || d_ack) begin
                a_if = if_ack; a_d = d_ack; a_err = err; a_grant = grant;
                $display("txn grant=%0d if_ack=%0d d_ack=%0d err=%0d if_rdata=%08h d_rdata=%08h latency=%0d",
                         grant, if_ack, d_ack, err, if_rdata, d_rdata, lat);
                return;
            end
        end
        n_checks++;
        n_errors++;
        $display("FAIL ack_timeout: no ack within %0d cycles", lat);
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) step();
        check("lit_reset_busy", busy, 0);
        check("lit_reset_if_rdata", if_rdata, 0);

        // Fetch only, memory ack one cycle after ISSUE
        mem_delay = 1; mem_data = 32'h2402000A;
        rst = 1'b1; if_req = 1'b1; if_addr = 30'h10;
        run_until_ack();
        if_req = 1'b0;
        check("fetch_ack", a_if, 1);
        check("fetch_latency", lat, 3);
        check("fetch_address", s_addr, 27'h10);
        check("fetch_rdata", if_rdata, 32'h2402000A);
        check("fetch_err", a_err, 0);
        step();

        // Both requesters after a fetch: data goes first
        mem_delay = 0; mem_data = 32'hAAAA0001;
        if_req = 1'b1; if_addr = 30'h44; d_rreq = 1'b1; d_addr = 30'h88;
        run_until_ack();
        d_rreq = 1'b0;
        check("rr_data_first", a_d, 1);
        check("rr_data_grant", a_grant, 1);
        check("rr_best_latency", lat, 2);
        mem_data = 32'hAAAA0002;
        run_until_ack();
        if_req = 1'b0;
        check("rr_fetch_second", a_if, 1);
        check("rr_d_rdata_held", d_rdata, 32'hAAAA0001);
        check("rr_if_rdata", if_rdata, 32'hAAAA0002);
        step();

        // Both requesters right after reset: fetch first, then data
        rst = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        mem_delay = 0; mem_data = 32'h11111111;
        if_req = 1'b1; if_addr = 30'h20; d_rreq = 1'b1; d_addr = 30'h30;
        run_until_ack();
        if_req = 1'b0;
        check("sim_first_fetch", a_if, 1);
        check("sim_first_grant", a_grant, 0);
        check("sim_first_addr", s_addr, 27'h20);
        mem_data = 32'h22222222;
        run_until_ack();
        d_rreq = 1'b0;
        check("sim_second_data", a_d, 1);
        check("sim_second_grant", a_grant, 1);
        check("sim_second_addr", s_addr, 27'h30);
        check("sim_if_rdata", if_rdata, 32'h11111111);
        check("sim_d_rdata", d_rdata, 32'h22222222);
        step();

        // Data write
        mem_delay = 2; mem_data = 32'h5A5A5A5A;
        d_wreq = 1'b1; d_addr = 30'h5; d_wdata = 32'hCAFEF00D;
        run_until_ack();
        d_wreq = 1'b0;
        check("wr_ack", a_d, 1);
        check("wr_wreq", s_wreq, 1);
        check("wr_no_rreq", s_rreq, 0);
        check("wr_wdata", s_wdata, 32'hCAFEF00D);
        check("wr_addr", s_addr, 27'h5);
        check("wr_err", a_err, 0);
        check("wr_latency", lat, 4);
        step();

        // Out-of-range data read
        mem_delay = 0; mem_data = 32'h33333333;
        d_rreq = 1'b1; d_addr = 30'h08000000;
        run_until_ack();
        d_rreq = 1'b0;
        check("oor_ack", a_d, 1);
        check("oor_no_rreq", s_rreq, 0);
        check("oor_no_wreq", s_wreq, 0);
        check("oor_rdata", d_rdata, 0);
        check("oor_err", a_err, 1);
        step();

        // Read and write together: performed as a write, flagged as an error
        mem_delay = 0; mem_data = 32'h77777777;
        d_rreq = 1'b1; d_wreq = 1'b1; d_addr = 30'h7; d_wdata = 32'h12345678;
        run_until_ack();
        d_rreq = 1'b0; d_wreq = 1'b0;
        check("conf_wreq", s_wreq, 1);
        check("conf_no_rreq", s_rreq, 0);
        check("conf_wdata", s_wdata, 32'h12345678);
        check("conf_err", a_err, 1);
        step();

        // Stray memory ack while idle must be ignored
        mem_data = 32'hDEADBEEF;
        kick_req++;
        repeat (3) step();
        check("stray_busy", busy, 0);
        check("stray_if_rdata", if_rdata, 32'h11111111);
        check("stray_d_rdata", d_rdata, 32'h77777777);

        // No memory ack: timeout when enabled, otherwise WAIT persists
        mem_delay = -1; mem_data = 32'h0BADF00D;
        if_req = 1'b1; if_addr = 30'h40;
        if (TO_EN) begin
            run_until_ack();
            check("to_ack", a_if, 1);
            check("to_err", a_err, 1);
            check("to_latency", lat, TO + 2);
            check("to_rdata", if_rdata, 0);
        end else begin
            repeat (12) step();
            check("nto_busy", busy, 1);
            check("nto_rreq", lpddr2_rreq, 1);
            kick_req++;
            run_until_ack();
            check("nto_ack", a_if, 1);
            check("nto_err", a_err, 0);
            check("nto_rdata", if_rdata, 32'h0BADF00D);
        end
        if_req = 1'b0;
        step();

        // Reset during WAIT drops the request at once; next fetch is normal
        mem_delay = -1;
        if_req = 1'b1; if_addr = 30'h50;
        step();
        step();
        check("mid_wait_rreq", lpddr2_rreq, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_rreq", lpddr2_rreq, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_if_ack", if_ack, 0);
        if_req = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        mem_delay = 0; mem_data = 32'h600DCAFE;
        if_req = 1'b1; if_addr = 30'h60;
        run_until_ack();
        if_req = 1'b0;
        check("post_rst_ack", a_if, 1);
        check("post_rst_latency", lat, 2);
        check("post_rst_rdata", if_rdata, 32'h600DCAFE);
        check("post_rst_addr", s_addr, 27'h60);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
